// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] WORD_MASK = ~ILEN'(3);

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: power-of-two ring of {pc, instr} entries with synchronous clear.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    output fetch_entry_t  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full buffer is fine when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count alone says which slots hold data.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: registered state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response capture,
// and flush handling that discards responses still in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int unsigned     DEPTH      = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [ILEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [ILEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [ILEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [ILEN-1:0] mtvec_i,
    input  logic            mret_i,
    input  logic [ILEN-1:0] mepc_i
);

    localparam int unsigned     CW           = $clog2(DEPTH) + 1;
    localparam logic [ILEN-1:0] START_PC     = word_align(RESET_ADDR);
    localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [ILEN-1:0] fetch_addr;
    logic [ILEN-1:0] rsp_pc;
    logic [ILEN-1:0] flush_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            flush;
    logic            credit_ok;
    logic            gnt_acc;
    logic            rsp_acc;
    logic            rsp_keep;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign flush = trap_i || mret_i || redirect_i;

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        flush_target = word_align(redirect_pc_i);
        if (trap_i) begin
            flush_target = word_align(mtvec_i);
        end else if (mret_i) begin
            flush_target = word_align(mepc_i);
        end
    end

    // Credit comes from registered occupancy only; a pop this cycle frees nothing yet.
    assign credit_ok   = !fifo_full
                      && (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT_LIMIT);
    assign imem_req_o  = !rst_i && credit_ok;
    assign imem_addr_o = fetch_addr;
    assign gnt_acc     = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is stray and leaves every counter alone.
    assign rsp_acc         = imem_rvalid_i && (outstanding != '0);
    assign rsp_keep        = rsp_acc && (drop == '0) && !flush;
    assign outstanding_nxt = outstanding + CW'(gnt_acc) - CW'(rsp_acc);

    assign push_entry.pc    = rsp_pc;
    assign push_entry.instr = imem_rdata_i;

    assign instr_valid_o = !rst_i && !fifo_empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign pop           = instr_valid_o && instr_ready_i && !flush;

    // rsp_pc is the address of the next response that will be kept; every grant
    // in flight at a flush is counted into drop, so that response maps to the target.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr  <= START_PC;
            rsp_pc      <= START_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (flush) begin
                fetch_addr <= flush_target;
                rsp_pc     <= flush_target;
                drop       <= outstanding_nxt;
            end else begin
                if (gnt_acc) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (rsp_acc && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush),
        .push  (rsp_keep),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assert property (@(posedge clk_i) disable iff (rst_i) outstanding <= CW'(DEPTH));
    assert property (@(posedge clk_i) disable iff (rst_i) drop <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory responder with hold/stray controls.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] mtvec_i;
    logic        mret_i;
    logic [31:0] mepc_i;

    logic        mem_hold;
    logic        stray;
    logic [31:0] pend_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [31:0] pop_cyc[$];
    int          cyc = 0;
    int          rel_cyc;
    int          gb;
    int          pb;
    int          n_tests = 0;
    int          n_fail = 0;

    fetch_unit #(
        .RESET_ADDR (RST_PC),
        .DEPTH      (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .mtvec_i       (mtvec_i),
        .mret_i        (mret_i),
        .mepc_i        (mepc_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Grants and consumed instructions are observed mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (imem_req_o && imem_gnt_i) begin
            pend_q.push_back(imem_addr_o);
            gnt_log.push_back(imem_addr_o);
        end
        if (instr_valid_o && instr_ready_i && !(trap_i || mret_i || redirect_i)) begin
            pop_pc.push_back(instr_pc_o);
            pop_ins.push_back(instr_o);
            pop_cyc.push_back(32'(cyc));
        end
    end

    // Answers one pending grant per cycle, earliest one cycle after the grant.
    always @(posedge clk) begin : responder
        logic [31:0] a;
        #1;
        if (rst_i) pend_q.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (stray) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end else if (!mem_hold && pend_q.size() != 0) begin
            a = pend_q.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(a);
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        imem_gnt_i = 1'b0;
        instr_ready_i = 1'b0;
        trap_i = 1'b0;
        mret_i = 1'b0;
        redirect_i = 1'b0;
        mem_hold = 1'b0;
        stray = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        rel_cyc = cyc;
        gb = gnt_log.size();
        pb = pop_pc.size();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        imem_gnt_i = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        trap_i = 1'b0;
        mtvec_i = '0;
        mret_i = 1'b0;
        mepc_i = '0;
        mem_hold = 1'b0;
        stray = 1'b0;

        // Reset values, then streaming at one instruction per cycle
        tick();
        tick();
        settle();
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        do_reset();
        imem_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        settle();
        check("t1_first_req", 32'(imem_req_o), 32'd1);
        check("t1_first_addr", imem_addr_o, RST_PC);
        repeat (6) tick();
        check("t1_pc0", q_at(pop_pc, pb), 32'h100);
        check("t1_pc1", q_at(pop_pc, pb + 1), 32'h104);
        check("t1_pc2", q_at(pop_pc, pb + 2), 32'h108);
        check("t1_instr1", q_at(pop_ins, pb + 1), instr_of(32'h104));
        check("t1_latency", q_at(pop_cyc, pb), 32'(rel_cyc + 2));
        check("t1_steady", q_at(pop_cyc, pb + 2), 32'(rel_cyc + 4));

        // Back-pressure: credit stops at 4, one pop frees exactly one request
        do_reset();
        imem_gnt_i = 1'b1;
        repeat (8) tick();
        settle();
        check("t2_grants", 32'(gnt_log.size() - gb), 32'd4);
        check("t2_req_off", 32'(imem_req_o), 32'd0);
        check("t2_head_pc", instr_pc_o, 32'h100);
        instr_ready_i = 1'b1;
        settle();
        check("t2_pop_no_credit", 32'(imem_req_o), 32'd0);
        tick();
        instr_ready_i = 1'b0;
        settle();
        check("t2_req_back", 32'(imem_req_o), 32'd1);
        check("t2_req_addr", imem_addr_o, 32'h110);
        check("t2_head_next", instr_pc_o, 32'h104);
        repeat (3) tick();
        settle();
        check("t2_one_more", 32'(gnt_log.size() - gb), 32'd5);
        check("t2_fifth_addr", q_at(gnt_log, gb + 4), 32'h110);
        check("t2_req_off2", 32'(imem_req_o), 32'd0);

        // Redirect with 2 outstanding plus a same-cycle grant
        do_reset();
        imem_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        mem_hold = 1'b1;
        tick();
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        settle();
        check("t3_grant_in_flush", 32'(imem_req_o), 32'd1);
        check("t3_flush_addr", imem_addr_o, 32'h108);
        tick();
        redirect_i = 1'b0;
        mem_hold = 1'b0;
        settle();
        check("t3_new_addr", imem_addr_o, 32'h200);
        check("t3_valid_after", 32'(instr_valid_o), 32'd0);
        repeat (10) tick();
        check("t3_first_pc", q_at(pop_pc, pb), 32'h200);
        check("t3_first_instr", q_at(pop_ins, pb), instr_of(32'h200));
        check("t3_first_cyc", q_at(pop_cyc, pb), 32'(rel_cyc + 8));
        check("t3_second_pc", q_at(pop_pc, pb + 1), 32'h204);

        // Flush priority and target alignment, flushing a full buffer
        do_reset();
        imem_gnt_i = 1'b1;
        repeat (8) tick();
        settle();
        check("t4_full_valid", 32'(instr_valid_o), 32'd1);
        trap_i = 1'b1;
        mtvec_i = 32'h80;
        mret_i = 1'b1;
        mepc_i = 32'h300;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h400;
        instr_ready_i = 1'b1;
        tick();
        trap_i = 1'b0;
        mret_i = 1'b0;
        redirect_i = 1'b0;
        settle();
        check("t4_valid_cleared", 32'(instr_valid_o), 32'd0);
        check("t4_req_after", 32'(imem_req_o), 32'd1);
        check("t4_trap_addr", imem_addr_o, 32'h80);
        pb = pop_pc.size();
        repeat (4) tick();
        check("t4_trap_pc", q_at(pop_pc, pb), 32'h80);
        mret_i = 1'b1;
        mepc_i = 32'h303;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h400;
        tick();
        mret_i = 1'b0;
        redirect_i = 1'b0;
        settle();
        check("t4_mret_addr", imem_addr_o, 32'h300);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h20B;
        tick();
        redirect_i = 1'b0;
        pb = pop_pc.size();
        settle();
        check("t4_redir_addr", imem_addr_o, 32'h208);
        repeat (8) tick();
        check("t4_redir_pc", q_at(pop_pc, pb), 32'h208);

        // Address wrap-around at the top of the address space
        do_reset();
        imem_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        redirect_i = 1'b0;
        gb = gnt_log.size();
        pb = pop_pc.size();
        repeat (6) tick();
        check("t5_addr0", q_at(gnt_log, gb), 32'hFFFF_FFF8);
        check("t5_addr1", q_at(gnt_log, gb + 1), 32'hFFFF_FFFC);
        check("t5_addr2", q_at(gnt_log, gb + 2), 32'h0000_0000);
        check("t5_pc2", q_at(pop_pc, pb + 2), 32'h0000_0000);
        check("t5_instr2", q_at(pop_ins, pb + 2), instr_of(32'h0));

        // Reset mid-burst with 3 outstanding, late responses must be ignored
        do_reset();
        imem_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        mem_hold = 1'b1;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        imem_gnt_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h500;
        mem_hold = 1'b0;
        stray = 1'b1;
        settle();
        check("t6_rst_req", 32'(imem_req_o), 32'd0);
        check("t6_rst_valid", 32'(instr_valid_o), 32'd0);
        tick();
        settle();
        check("t6_rst_req2", 32'(imem_req_o), 32'd0);
        redirect_i = 1'b0;
        tick();
        rst_i = 1'b0;
        pb = pop_pc.size();
        settle();
        check("t6_refetch_req", 32'(imem_req_o), 32'd1);
        check("t6_refetch_addr", imem_addr_o, RST_PC);
        tick();
        stray = 1'b0;
        tick();
        settle();
        check("t6_stray_ignored", 32'(instr_valid_o), 32'd0);
        check("t6_credit_intact", 32'(imem_req_o), 32'd1);
        imem_gnt_i = 1'b1;
        repeat (4) tick();
        check("t6_first_pc", q_at(pop_pc, pb), RST_PC);
        check("t6_first_instr", q_at(pop_ins, pb), instr_of(RST_PC));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
